// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
//   state_e        : loader FSM states
//   LEN_BYTES      : bytes in the little-endian word-count header
//   BYTES_PER_WORD : bytes per instruction word
package uart_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_DONE
  } state_e;

  localparam int unsigned LEN_BYTES      = 4;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Bundle of the loader's UART-side input and imem/CPU-control outputs.
//   rx_valid/rx_byte          : one-cycle byte strobe from the UART receiver
//   imem_we/addr/wdata        : instruction-memory write port
//   cpu_hold/load_done/error  : CPU hold and sticky load status
// master = loader side, slave = environment side.
interface uart_prog_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  modport master (
    input  rx_valid, rx_byte,
    output imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_error
  );

  modport slave (
    output rx_valid, rx_byte,
    input  imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_error
  );
endinterface

// File: rtl/uart_word_assembler.sv
// Collects 4 bytes little-endian (first byte -> [7:0]) into a 32-bit word.
//   clk, reset    : clock, synchronous active-high reset
//   clear_i       : drop any partially assembled word
//   byte_valid_i  : byte strobe
//   byte_i        : byte value
//   word_ready_o  : combinational pulse in the cycle the 4th byte arrives
//   word_o        : assembled word, valid with word_ready_o
module uart_word_assembler
  import uart_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_ready_o,
  output logic [31:0] word_o
);

  // Header and data words share this assembler, so it spans the longer of the two.
  localparam int unsigned NBYTES   = (LEN_BYTES > BYTES_PER_WORD) ? LEN_BYTES : BYTES_PER_WORD;
  localparam logic [1:0]  LAST_IDX = 2'(NBYTES - 1);

  logic [1:0]  cnt_q;
  logic [23:0] shift_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (byte_valid_i) begin
      case (cnt_q)
        2'd0:    shift_q[7:0]   <= byte_i;
        2'd1:    shift_q[15:8]  <= byte_i;
        2'd2:    shift_q[23:16] <= byte_i;
        default: ;
      endcase
      cnt_q <= (cnt_q == LAST_IDX) ? '0 : cnt_q + 2'd1;
    end
  end

  // The 4th byte bypasses the shift register so the word is usable in the same cycle.
  assign word_ready_o = byte_valid_i && !clear_i && (cnt_q == LAST_IDX);
  assign word_o       = {byte_i, shift_q};

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: parses a 4-byte little-endian word count, then turns each
// following 4-byte group into one imem write; holds the CPU until done.
//   clk, reset : clock, synchronous active-high reset
//   bus        : uart_prog_loader_if.master (rx byte in, imem write + status out)
module uart_prog_loader
  import uart_loader_pkg::*;
#(
  parameter logic [31:0] IMEM_BASE      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
)(
  input  logic               clk,
  input  logic               reset,
  uart_prog_loader_if.master bus
);

  state_e      state_q;
  logic [31:0] len_q;
  logic [31:0] word_idx_q;
  logic [31:0] idle_cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        hold_q;
  logic        done_q;
  logic        err_q;

  logic        in_load;
  logic        timeout_hit;
  logic        last_write;
  logic        asm_clear;
  logic        asm_ready;
  logic [31:0] asm_word;

  always_comb begin
    in_load     = (state_q == ST_LEN) || (state_q == ST_DATA);
    timeout_hit = in_load && !bus.rx_valid && (idle_cnt_q == 32'(TIMEOUT_CYCLES - 1));
    last_write  = (state_q == ST_DATA) && we_q && (word_idx_q == len_q - 32'd1);
    asm_clear   = timeout_hit || last_write;
  end

  uart_word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (asm_clear),
    .byte_valid_i (bus.rx_valid),
    .byte_i       (bus.rx_byte),
    .word_ready_o (asm_ready),
    .word_o       (asm_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      idle_cnt_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= IMEM_BASE;
      wdata_q    <= '0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_q <= 1'b0;

      if (bus.rx_valid || !in_load) idle_cnt_q <= '0;
      else                          idle_cnt_q <= idle_cnt_q + 32'd1;

      case (state_q)
        ST_IDLE: begin
          if (bus.rx_valid) state_q <= ST_LEN;
        end

        ST_LEN: begin
          if (timeout_hit) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else if (asm_ready) begin
            len_q <= asm_word;
            if (asm_word == '0) begin
              state_q <= ST_DONE;
              hold_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (asm_word > 32'(MAX_WORDS)) begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              err_q      <= 1'b0;
              word_idx_q <= '0;
              state_q    <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (timeout_hit) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            // Index advances in the write cycle, so a byte accepted then
            // already belongs to the next word.
            if (last_write) begin
              state_q <= ST_DONE;
              hold_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (we_q) begin
              word_idx_q <= word_idx_q + 32'd1;
            end
            if (asm_ready) begin
              we_q    <= 1'b1;
              addr_q  <= IMEM_BASE + {word_idx_q[29:0], 2'b00};
              wdata_q <= asm_word;
            end
          end
        end

        ST_DONE: begin
          if (bus.rx_valid) begin
            state_q <= ST_LEN;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.cpu_hold   = hold_q;
  assign bus.load_done  = done_q;
  assign bus.load_error = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
module tb_uart_prog_loader;

  localparam int unsigned MAXW = 1024;
  localparam int unsigned TMO  = 1000;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_prog_loader_if bus ();

  uart_prog_loader #(
    .IMEM_BASE      (BASE),
    .MAX_WORDS      (MAXW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned cyc;
    bit          last;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] pay[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a write.
  bit  prev_we   = 1'b0;
  bit  pend_last = 1'b0;
  wr_t mon_e;
  always @(negedge clk) begin
    if (reset) begin
      prev_we   = 1'b0;
      pend_last = 1'b0;
    end else begin
      if (pend_last) begin
        check("done_after_last_write", 32'(bus.load_done), 32'd1);
        check("hold_after_last_write", 32'(bus.cpu_hold), 32'd0);
        pend_last = 1'b0;
      end
      if (bus.imem_we) begin
        check("strobe_single_cycle", 32'(prev_we), 32'd0);
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write", bus.imem_addr, bus.imem_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_addr", bus.imem_addr, mon_e.addr);
          check("write_data", bus.imem_wdata, mon_e.data);
          check("write_cycle", cyc, mon_e.cyc);
          check("hold_during_write", 32'(bus.cpu_hold), 32'd1);
          pend_last = mon_e.last;
        end
      end
      prev_we = bus.imem_we;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    sync();
    bus.rx_valid = 1'b0;
    repeat (gap) sync();
  endtask

  task automatic fill_pay(input int unsigned n);
    pay.delete();
    repeat (n) pay.push_back($urandom());
  endtask

  // Reference model: a header n in 1..MAXW yields n writes at BASE+4*i,
  // each visible the cycle after the word's last byte is presented.
  task automatic do_load(input logic [31:0] n, input int unsigned max_gap);
    bit          ok;
    logic [31:0] w;
    wr_t         e;
    ok = (n >= 1) && (n <= MAXW);
    for (int b = 0; b < 4; b++)
      send_byte(n[8*b +: 8], (b == 3 && !ok) ? 0 : $urandom_range(max_gap, 0));
    if (ok) begin
      for (int unsigned i = 0; i < n; i++) begin
        w = pay[i];
        for (int b = 0; b < 4; b++) begin
          if (b == 3) begin
            e.addr = BASE + 32'(4 * i);
            e.data = w;
            e.cyc  = cyc + 1;
            e.last = (i == n - 1);
            exp_q.push_back(e);
          end
          send_byte(w[8*b +: 8], (i == n - 1 && b == 3) ? 0 : $urandom_range(max_gap, 0));
        end
      end
    end
  endtask

  task automatic check_flags(input string tag, input bit done, input bit hold, input bit err);
    @(negedge clk);
    check({tag, "_load_done"}, 32'(bus.load_done), 32'(done));
    check({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'(hold));
    check({tag, "_load_error"}, 32'(bus.load_error), 32'(err));
    sync();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_imem_we"}, 32'(bus.imem_we), 32'd0);
    check({tag, "_imem_addr"}, bus.imem_addr, BASE);
    check({tag, "_imem_wdata"}, bus.imem_wdata, 32'd0);
    check({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'd1);
    check({tag, "_load_done"}, 32'(bus.load_done), 32'd0);
    check({tag, "_load_error"}, 32'(bus.load_error), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] n;
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    sync();

    // Two-word load with the documented byte stream, back to back
    pay.delete();
    pay.push_back(32'h0000_0013);
    pay.push_back(32'h0010_0093);
    do_load(32'd2, 0);
    repeat (2) sync();
    check_flags("two_word", 1'b1, 1'b0, 1'b0);

    // Zero-length header, started from DONE
    send_byte(8'h00, 0);
    @(negedge clk);
    check("restart_cpu_hold", 32'(bus.cpu_hold), 32'd1);
    check("restart_load_done", 32'(bus.load_done), 32'd0);
    sync();
    send_byte(8'h00, 0);
    send_byte(8'h00, 1);
    send_byte(8'h00, 0);
    check_flags("zero_len", 1'b1, 1'b0, 1'b0);

    // Oversized header, then a good load clears the error
    do_load(32'd1025, 0);
    check_flags("too_long", 1'b0, 1'b1, 1'b1);
    fill_pay(1);
    do_load(32'd1, 2);
    repeat (2) sync();
    check_flags("after_too_long", 1'b1, 1'b0, 1'b0);

    // Timeout in the middle of a word
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    repeat (TMO - 1) sync();
    @(negedge clk);
    check("timeout_not_early", 32'(bus.load_error), 32'd0);
    sync();
    check_flags("timeout", 1'b0, 1'b1, 1'b1);
    fill_pay(1);
    do_load(32'd1, 1);
    repeat (2) sync();
    check_flags("after_timeout", 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a two-word load
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h5A, 0);
    send_byte(8'hA5, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("mid_reset");
    reset = 1'b0;
    sync();
    fill_pay(1);
    do_load(32'd1, 0);
    repeat (2) sync();
    check_flags("after_mid_reset", 1'b1, 1'b0, 1'b0);

    // Largest accepted count
    fill_pay(MAXW);
    do_load(32'(MAXW), 0);
    repeat (2) sync();
    check_flags("max_words", 1'b1, 1'b0, 1'b0);

    // Randomized loads with random inter-byte gaps
    for (int t = 0; t < 10; t++) begin
      if ($urandom_range(4, 0) == 0) begin
        n = 32'($urandom_range(4000, MAXW + 1));
        do_load(n, 2);
        check_flags("rand_bad", 1'b0, 1'b1, 1'b1);
      end else begin
        n = 32'($urandom_range(6, 1));
        fill_pay(n);
        do_load(n, 3);
        repeat (2) sync();
        check_flags("rand_ok", 1'b1, 1'b0, 1'b0);
      end
    end

    repeat (3) sync();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
